sub_multicycle: RTL and testbench
=================================

# sub_multicycle

Parametrised multi-cycle subtractor, successor to the 32-bit combinational ripple subtractor in the ALU datapath. Computes `x - y - bin` over WIDTH bits, DIGIT bits per clock, with a start/done handshake. Reports unsigned borrow, signed overflow, zero and negative flags. Used by multi-cycle ALU ops and compare paths where a full-width ripple chain would limit clock frequency.

## Interface
- `WIDTH`, 32: operand and result width; must be a multiple of DIGIT.
- `DIGIT`, 8: bits processed per cycle. N = WIDTH/DIGIT is the digit count.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when `ready`=1.
- `x` in WIDTH: minuend; sampled with `start`.
- `y` in WIDTH: subtrahend; sampled with `start`.
- `bin` in 1: borrow-in; sampled with `start`.
- `ready` out 1: 1 in IDLE and DONE; a new `start` is accepted.
- `done` out 1: one-cycle pulse; results valid and updated.
- `difference` out WIDTH: result register.
- `borrow` out 1: unsigned borrow-out (x < y + bin).
- `overflow` out 1: signed two's-complement overflow of the raw result.
- `zero` out 1: `difference` == 0.
- `negative` out 1: `difference[WIDTH-1]`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`=1, latch x, y, bin into internal operand shift registers and the borrow register, clear digit counter, latch x/y sign bits, go to RUN.
- RUN: `ready`=0. Each cycle:
  - Subtract the low DIGIT bits of the operand registers with the borrow register: DIGIT-bit result plus borrow-out.
  - Shift the result into the internal result register from the MSB side.
  - Shift the operands right by DIGIT.
  - Store the borrow-out; increment the counter.
  - After digit N-1, go to DONE.
- DONE (one cycle):
  - Assert `done`; load `difference` and all flags from the internal result.
  - `ready`=1. `start`=1 here is accepted as in IDLE (back-to-back, next state RUN); otherwise go to IDLE.
- `start` in RUN is ignored and not queued.
- Raw flags:
  - borrow = final borrow register.
  - overflow = (x_msb != y_msb) && (raw_msb != x_msb).
- `difference`, `borrow`, `overflow`, `zero` and `negative` hold their values until the next DONE.
- Arithmetic is modulo 2^WIDTH; no sign extension internally.

## Timing
- Reset (async, immediate): state IDLE; `ready`=1, `done`=0, `difference`=0, `borrow`=0, `overflow`=0, `zero`=1, `negative`=0; internal registers cleared.
- Latency: `start` accepted at edge 0 -> RUN for edges 1..N -> `done`=1 with valid results during the cycle after edge N.
- Throughput: one operation per N+1 cycles, including back-to-back starts.
- `rst` during RUN or DONE aborts the operation. No `done` is produced for the aborted op, and outputs take their reset values.
- N=1 (DIGIT=WIDTH) is legal: one RUN cycle, then DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SUB_MULTICYCLE_SAT_EN` defined: saturating signed mode.
  - When raw overflow=1, `difference` is clamped: 2^(WIDTH-1)-1 if x is non-negative, else -2^(WIDTH-1).
  - `zero` and `negative` reflect the clamped value.
  - `overflow` and `borrow` still report raw-result conditions.
- `SUB_MULTICYCLE_SAT_EN` undefined: `difference` is the raw wrapped result.

## Test plan
All scenarios use WIDTH=32, DIGIT=8 (N=4).
- x=5, y=3, bin=0 -> `difference`=0x00000002; borrow=0, overflow=0, zero=0, negative=0; `done` in the 5th cycle after the start edge, high exactly one cycle.
- x=0, y=1, bin=0 -> `difference`=0xFFFFFFFF; borrow=1, negative=1, overflow=0. Then x=y=0x12345678, bin=0 -> `difference`=0, zero=1. Then same operands with bin=1 -> 0xFFFFFFFF, borrow=1.
- x=0x80000000, y=1 -> overflow=1, borrow=0.
  - Without `SUB_MULTICYCLE_SAT_EN`: `difference`=0x7FFFFFFF, negative=0.
  - With it: `difference`=0x80000000, negative=1.
- x=0x7FFFFFFF, y=0xFFFFFFFF -> raw 0x80000000, overflow=1, borrow=1.
  - With `SUB_MULTICYCLE_SAT_EN`: `difference`=0x7FFFFFFF.
  - Without it: `difference`=0x80000000.
- Handshake:
  - `start` pulsed during RUN with different operands -> ignored; the first result is unchanged.
  - `start` held in the DONE cycle -> second op accepted; its `done` follows 5 cycles later.
- Reset in the 2nd RUN cycle -> outputs immediately take reset values (zero=1, ready=1); no `done` for the aborted op; a fresh start after reset release produces the correct result.

Source files
------------

// File: rtl/sub_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : sub_multicycle
// Purpose  : Digit-serial x - y - bin subtractor, DIGIT bits/clock, with
//            start/done handshake and borrow/overflow/zero/negative flags.
//            Optional macro SUB_MULTICYCLE_SAT_EN enables saturating signed mode.
// Revision : 1.0 - initial release
// ============================================================================
module sub_multicycle #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] c_last = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_res;
   logic             r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_xs;
   logic             r_ys;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_difference;
   logic             r_borrow;
   logic             r_overflow;
   logic             r_zero;
   logic             r_negative;

   logic [DIGIT:0]   w_digit;
   logic [WIDTH-1:0] w_res_next;
   logic             w_raw_ovf;
   logic [WIDTH-1:0] w_final;

   // One digit of the ripple chain; bit DIGIT of the result is the borrow-out.
   assign w_digit = {1'b0, r_x[DIGIT-1:0]} - {1'b0, r_y[DIGIT-1:0]}
                  - {{DIGIT{1'b0}}, r_b};

   generate
      if (N > 1) begin : g_multi
         assign w_res_next = {w_digit[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
      end else begin : g_single
         assign w_res_next = w_digit[DIGIT-1:0];
      end
   endgenerate

   assign w_raw_ovf = (r_xs != r_ys) && (w_res_next[WIDTH-1] != r_xs);

`ifdef SUB_MULTICYCLE_SAT_EN
   assign w_final = !w_raw_ovf ? w_res_next :
                    r_xs       ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_final = w_res_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_res        <= '0;
         r_b          <= 1'b0;
         r_cnt        <= '0;
         r_xs         <= 1'b0;
         r_ys         <= 1'b0;
         r_ready      <= 1'b1;
         r_done       <= 1'b0;
         r_difference <= '0;
         r_borrow     <= 1'b0;
         r_overflow   <= 1'b0;
         r_zero       <= 1'b1;
         r_negative   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_x     <= x;
                  r_y     <= y;
                  r_b     <= bin;
                  r_xs    <= x[WIDTH-1];
                  r_ys    <= y[WIDTH-1];
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_res <= w_res_next;
               r_x   <= r_x >> DIGIT;
               r_y   <= r_y >> DIGIT;
               r_b   <= w_digit[DIGIT];
               r_cnt <= r_cnt + CW'(1);
               // Results are registered on the last digit so they are valid in DONE.
               if (r_cnt == c_last) begin
                  r_state      <= S_DONE;
                  r_ready      <= 1'b1;
                  r_done       <= 1'b1;
                  r_difference <= w_final;
                  r_borrow     <= w_digit[DIGIT];
                  r_overflow   <= w_raw_ovf;
                  r_zero       <= (w_final == '0);
                  r_negative   <= w_final[WIDTH-1];
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready      = r_ready;
   assign done       = r_done;
   assign difference = r_difference;
   assign borrow     = r_borrow;
   assign overflow   = r_overflow;
   assign zero       = r_zero;
   assign negative   = r_negative;

endmodule
`default_nettype wire

// File: tb/tb_sub_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_multicycle
// Purpose  : Directed self-checking bench for sub_multicycle (WIDTH=32, DIGIT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_multicycle;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        bin = 1'b0;
   logic        ready;
   logic        done;
   logic [31:0] difference;
   logic        borrow;
   logic        overflow;
   logic        zero;
   logic        negative;

   int n_err = 0;
   int n_chk = 0;

   sub_multicycle #(.WIDTH(32), .DIGIT(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x          (x),
      .y          (y),
      .bin        (bin),
      .ready      (ready),
      .done       (done),
      .difference (difference),
      .borrow     (borrow),
      .overflow   (overflow),
      .zero       (zero),
      .negative   (negative)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic c);
      start = 1'b1;
      x     = a;
      y     = b;
      bin   = c;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 20);
   endtask

   task automatic chk_res(input string tag, input logic [31:0] d, input logic b,
                          input logic o, input logic z, input logic n);
      chk({tag, "_diff"}, difference, d);
      chk({tag, "_borrow"}, {31'd0, borrow}, {31'd0, b});
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, o});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
      chk({tag, "_neg"}, {31'd0, negative}, {31'd0, n});
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] ed, input logic eb,
                        input logic eo, input logic ez);
      int lat;
      @(negedge clk);
      launch(a, b, c);
      wait_done(lat);
      chk({tag, "_lat"}, lat, 5);
      chk_res(tag, ed, eb, eo, ez, ed[31]);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int lat;
      int seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk_res("rst", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

      do_op("basic", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      do_op("under", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      do_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      do_op("eqbin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
`ifdef SUB_MULTICYCLE_SAT_EN
      do_op("ovfneg", 32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      do_op("ovfpos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`else
      do_op("ovfneg", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      do_op("ovfpos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif
      do_op("carry", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

      // start pulsed mid-operation must be neither taken nor queued
      @(negedge clk);
      launch(32'd100, 32'd1, 1'b0);
      @(negedge clk);
      chk("ign_ready", {31'd0, ready}, 32'd0);
      start = 1'b1;
      x     = 32'd7;
      y     = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk("ign_lat", lat, 3);
      chk("ign_diff", difference, 32'h0000_0063);
      @(negedge clk);
      chk("ign_idle_ready", {31'd0, ready}, 32'd1);
      chk("ign_pulse", {31'd0, done}, 32'd0);

      // back-to-back start while in DONE
      launch(32'd10, 32'd20, 1'b0);
      wait_done(lat);
      chk("b2b_a_lat", lat, 5);
      chk("b2b_a_diff", difference, 32'hFFFF_FFF6);
      chk("b2b_done_ready", {31'd0, ready}, 32'd1);
      launch(32'h30, 32'h10, 1'b0);
      wait_done(lat);
      chk("b2b_b_lat", lat, 5);
      chk_res("b2b_b", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset in the second RUN cycle aborts the op
      @(negedge clk);
      launch(32'h55, 32'h11, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk_res("abort", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      do_op("post", 32'h0000_1000, 32'd1, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
